// File: rtl/cla_nibble_subtractor.sv
// cla_nibble_subtractor: multi-cycle a - b - bin, one carry-lookahead nibble per clock, LSB first
module cla_nibble_subtractor #(
  parameter int WIDTH = 16,
  parameter int NIBS  = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int CW = $clog2(NIBS);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       state;
  logic [WIDTH-1:0] ra, rb;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic [3:0]       an, bn, g, p, s;
  logic [4:0]       c;
  logic             last;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign last      = cnt == CW'(NIBS - 1);
  // Subtraction as a + ~b + ~borrow; borrow between nibbles travels only through brw.
  always_comb begin
    an   = ra[{cnt, 2'b00} +: 4];
    bn   = ~rb[{cnt, 2'b00} +: 4];
    g    = an & bn;
    p    = an | bn;
    c[0] = ~brw;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s    = an ^ bn ^ c[3:0];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        ra    <= a;
        rb    <= b;
        brw   <= bin;
        cnt   <= '0;
        state <= RUN;
      end
    end else if (state == RUN) begin
      diff[{cnt, 2'b00} +: 4] <= s;
      brw <= ~c[4];
      cnt <= cnt + 1'b1;
      if (last) begin
        bout  <= ~c[4];
        ovf   <= (ra[WIDTH-1] != rb[WIDTH-1]) & (s[3] != ra[WIDTH-1]);
        state <= DONE;
      end
    end else if (out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_cla_nibble_subtractor.sv
// tb_cla_nibble_subtractor: directed vector table plus backpressure and mid-run reset sequences
module tb_cla_nibble_subtractor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
  int          checks = 0;
  int          errors = 0;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } vec_t;
  vec_t v [0:9];
  cla_nibble_subtractor #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done(input string n, output int lat);
    lat = 0;
    while (!out_valid && lat <= 20) begin
      tick();
      lat++;
    end
    chk({n, " latency"}, lat, 4);
  endtask
  task automatic op(input string n, input logic [15:0] xa, input logic [15:0] xb, input logic xbin,
                    input logic [15:0] ed, input logic ebo, input logic eov);
    int lat;
    a = xa;
    b = xb;
    bin = xbin;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = ~xa;
    b = ~xb;
    bin = ~xbin;
    wait_done(n, lat);
    chk({n, " diff"}, diff, ed);
    chk({n, " bout"}, bout, ebo);
    chk({n, " ovf"}, ovf, eov);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({n, " in_ready after"}, in_ready, 1);
    chk({n, " out_valid after"}, out_valid, 0);
  endtask
  initial begin
    int lat;
    v[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    v[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    v[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    v[3] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    v[4] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    v[5] = '{16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b0};
    v[6] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    v[7] = '{16'hFFFF, 16'h8000, 1'b0, 16'h7FFF, 1'b0, 1'b0};
    v[8] = '{16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1};
    v[9] = '{16'h0F0F, 16'h0F10, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    // reset held with in_valid high: nothing may be accepted
    in_valid = 1'b1;
    a = 16'h1111;
    tick();
    tick();
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset diff", diff, 0);
    chk("reset bout", bout, 0);
    chk("reset ovf", ovf, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("idle after reset", in_ready, 1);
    for (int i = 0; i < 10; i++) op($sformatf("vec%0d", i), v[i].a, v[i].b, v[i].bin, v[i].d, v[i].bo, v[i].ov);
    // backpressure, with in_valid held high and a second operand presented during RUN
    a = 16'h00F0;
    b = 16'h000F;
    bin = 1'b0;
    in_valid = 1'b1;
    tick();
    a = 16'h1111;
    b = 16'h0001;
    wait_done("bp", lat);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp diff", diff, 16'h00E1);
      chk("bp out_valid", out_valid, 1);
      chk("bp in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp in_ready idle", in_ready, 1);
    chk("bp out_valid idle", out_valid, 0);
    tick();
    in_valid = 1'b0;
    chk("bp second accepted", in_ready, 0);
    wait_done("bp2", lat);
    chk("bp2 diff", diff, 16'h1110);
    chk("bp2 bout", bout, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    // reset while the nibble counter is at 2
    a = 16'hFFFF;
    b = 16'h0001;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst in_ready", in_ready, 1);
    chk("midrst diff", diff, 0);
    chk("midrst bout", bout, 0);
    op("post_rst", 16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
